sensor_conditioner: RTL

- Front-end stage that sits directly upstream of the sensor synchronizer/state counter in the train controller.
- Takes the six raw track sensors (S1..S6), double-flop synchronizes them, debounces each one and emits clean levels plus one-cycle rising-edge events.
- Encodes the event as a sensor ID for the state logic.
- Flags two faults: simultaneous multi-sensor hits and sensors stuck active.

---
 rtl/sensor_conditioner.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sensor_conditioner.sv
// ============================================================================
//  Module   : sensor_conditioner
//  Purpose  : Synchronize, debounce and edge-detect raw track sensors; encode
//             the rising sensor ID and flag multi-hit / stuck-active faults.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sensor_conditioner #(
    parameter int N_SENS      = 6,
    parameter int DEBOUNCE    = 16,
    parameter int CNT_W       = 5,
    parameter int STUCK_LIMIT = 1024,
    parameter int STUCK_W     = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SENS-1:0] sens_raw,
    input  logic              en,
    input  logic              clr_fault,
    output logic [N_SENS-1:0] sens_level,
    output logic [N_SENS-1:0] sens_rise,
    output logic              sens_valid,
    output logic [2:0]        sens_id,
    output logic              multi_hit,
    output logic [N_SENS-1:0] stuck
);

    localparam logic [CNT_W-1:0]   c_DEB_MAX   = CNT_W'(DEBOUNCE - 1);
    localparam logic [STUCK_W-1:0] c_STUCK_MAX = STUCK_W'(STUCK_LIMIT);
    localparam logic [STUCK_W-1:0] c_STUCK_PRE = STUCK_W'(STUCK_LIMIT - 1);

    logic [N_SENS-1:0] r_meta;
    logic [N_SENS-1:0] r_sync;
    logic [N_SENS-1:0] w_level;
    logic [N_SENS-1:0] w_stuck;
    logic [N_SENS-1:0] w_rise_next;
    logic [2:0]        w_id_next;
    logic [N_SENS-1:0] r_rise;
    logic              r_valid;
    logic [2:0]        r_id;
    logic              r_multi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= sens_raw;
            r_sync <= r_meta;
        end
    end

    for (genvar i = 0; i < N_SENS; i++) begin : g_chan
        logic [CNT_W-1:0]   r_deb_cnt;
        logic [STUCK_W-1:0] r_stuck_cnt;
        logic               r_lvl;
        logic               r_flag;
        logic               w_mismatch;
        logic               w_accept;
        logic               w_stuck_hit;
        logic               w_stuck_held;

        assign w_mismatch     = r_sync[i] ^ r_lvl;
        assign w_accept       = en & w_mismatch & (r_deb_cnt == c_DEB_MAX);
        assign w_rise_next[i] = w_accept & r_sync[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_deb_cnt <= '0;
                r_lvl     <= 1'b0;
            end else if (en) begin
                if (!w_mismatch) begin
                    r_deb_cnt <= '0;
                end else if (r_deb_cnt == c_DEB_MAX) begin
                    r_lvl     <= r_sync[i];
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + CNT_W'(1);
                end
            end
        end

        // Hitting the limit is the real set event and beats clr_fault; an
        // already-saturated counter only re-flags on the cycle after a clear.
        assign w_stuck_hit  = en & r_lvl & (r_stuck_cnt == c_STUCK_PRE);
        assign w_stuck_held = en & r_lvl & (r_stuck_cnt == c_STUCK_MAX);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_stuck_cnt <= '0;
                r_flag      <= 1'b0;
            end else begin
                if (!r_lvl) begin
                    r_stuck_cnt <= '0;
                end else if (en && (r_stuck_cnt != c_STUCK_MAX)) begin
                    r_stuck_cnt <= r_stuck_cnt + STUCK_W'(1);
                end
                r_flag <= w_stuck_hit | (w_stuck_held & ~clr_fault) | (r_flag & ~clr_fault);
            end
        end

        assign w_level[i] = r_lvl;
        assign w_stuck[i] = r_flag;
    end : g_chan

    always_comb begin
        w_id_next = 3'd0;
        for (int i = N_SENS - 1; i >= 0; i--) begin
            if (w_rise_next[i]) begin
                w_id_next = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise  <= '0;
            r_valid <= 1'b0;
            r_id    <= 3'd0;
            r_multi <= 1'b0;
        end else begin
            r_rise  <= w_rise_next;
            r_valid <= |w_rise_next;
            r_id    <= w_id_next;
            // x & (x-1) is non-zero exactly when two or more bits are set
            r_multi <= (|(r_rise & (r_rise - N_SENS'(1)))) | (r_multi & ~clr_fault);
        end
    end

    assign sens_level = w_level;
    assign sens_rise  = r_rise;
    assign sens_valid = r_valid;
    assign sens_id    = r_id;
    assign multi_hit  = r_multi;
    assign stuck      = w_stuck;

endmodule

`default_nettype wire
